// File: rtl/soc_ctrl_pkg.sv
// ============================================================================
//  Module      : soc_ctrl_pkg
//  Description : Shared types and constants for the clock/reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package soc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_PRED = 2'd1,
        ST_COUNT     = 2'd2,
        ST_READY     = 2'd3
    } soc_ctrl_seq_state_e;

    localparam int c_SEQ_MODE_INDEP = 0;
    localparam int c_SEQ_MODE_CHAIN = 1;

endpackage : soc_ctrl_pkg

`default_nettype wire

// File: rtl/soc_ctrl_clk_rst_seq_ch.sv
// ============================================================================
//  Module      : soc_ctrl_clk_rst_seq_ch
//  Description : One clock/reset channel: reset synchroniser, release FSM and
//                delay counter, with optional dependency on a predecessor.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module soc_ctrl_clk_rst_seq_ch
    import soc_ctrl_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int SEQ_MODE = c_SEQ_MODE_CHAIN,
    parameter bit HAS_PRED = 1'b1
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             ch_arst_ni,
    input  logic             ch_clk_en_i,
    input  logic [CNT_W-1:0] delay_i,
    input  logic             pred_ready_i,
    output logic             ch_clk_en_o,
    output logic             ch_ready_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [1:0]          sync_q;
    soc_ctrl_seq_state_e state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                w_rst_sync;
    logic                w_hold;

    assign w_rst_sync = sync_q[1];
    assign w_hold     = (SEQ_MODE == c_SEQ_MODE_CHAIN) && HAS_PRED && !pred_ready_i;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync_q  <= 2'b00;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], ch_arst_ni};
            if (!w_rst_sync) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    // IDLE and WAIT_PRED share the same release decision.
                    ST_IDLE, ST_WAIT_PRED: begin
                        if (w_hold) begin
                            state_q <= ST_WAIT_PRED;
                            cnt_q   <= '0;
                        end else if (delay_i != '0) begin
                            state_q <= ST_COUNT;
                            cnt_q   <= delay_i;
                        end else begin
                            state_q <= ST_READY;
                            cnt_q   <= '0;
                        end
                    end
                    ST_COUNT: begin
                        if (w_hold) begin
                            state_q <= ST_WAIT_PRED;
                            cnt_q   <= '0;
                        end else if (cnt_q <= c_CNT_ONE) begin
                            state_q <= ST_READY;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q - c_CNT_ONE;
                        end
                    end
                    ST_READY: begin
                        if (w_hold) begin
                            state_q <= ST_WAIT_PRED;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    // The synchronised reset term drops the gate in the same cycle it falls.
    assign ch_clk_en_o = ch_clk_en_i && (state_q == ST_READY) && w_rst_sync;
    assign ch_ready_o  = (state_q == ST_READY);
    assign busy_o      = (state_q == ST_WAIT_PRED) || (state_q == ST_COUNT);

endmodule : soc_ctrl_clk_rst_seq_ch

`default_nettype wire

// File: rtl/soc_ctrl_clk_rst_seq.sv
// ============================================================================
//  Module      : soc_ctrl_clk_rst_seq
//  Description : Multi-channel clock-enable / reset release sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module soc_ctrl_clk_rst_seq
    import soc_ctrl_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 8,
    parameter int SEQ_MODE = c_SEQ_MODE_CHAIN
) (
    input  logic                         clk_i,
    input  logic                         arst_i,
    input  logic [NUM_CH-1:0]            ch_arst_ni,
    input  logic [NUM_CH-1:0]            ch_clk_en_i,
    input  logic [NUM_CH-1:0][CNT_W-1:0] delay_i,
    output logic [NUM_CH-1:0]            ch_clk_en_o,
    output logic [NUM_CH-1:0]            ch_ready_o,
    output logic                         busy_o
);

    logic [NUM_CH-1:0] w_pred_ready;
    logic [NUM_CH-1:0] w_busy;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        // Channel 0 heads the chain, so it always sees its predecessor ready.
        if (k == 0) begin : g_head
            assign w_pred_ready[k] = 1'b1;
        end else begin : g_tail
            assign w_pred_ready[k] = ch_ready_o[k-1];
        end

        soc_ctrl_clk_rst_seq_ch #(
            .CNT_W    (CNT_W),
            .SEQ_MODE (SEQ_MODE),
            .HAS_PRED (k > 0)
        ) u_ch (
            .clk_i        (clk_i),
            .arst_i       (arst_i),
            .ch_arst_ni   (ch_arst_ni[k]),
            .ch_clk_en_i  (ch_clk_en_i[k]),
            .delay_i      (delay_i[k]),
            .pred_ready_i (w_pred_ready[k]),
            .ch_clk_en_o  (ch_clk_en_o[k]),
            .ch_ready_o   (ch_ready_o[k]),
            .busy_o       (w_busy[k])
        );
    end

    assign busy_o = |w_busy;

endmodule : soc_ctrl_clk_rst_seq

`default_nettype wire

// File: tb/tb_soc_ctrl_clk_rst_seq.sv
// ============================================================================
//  Module      : tb_soc_ctrl_clk_rst_seq
//  Description : Self-checking bench; READY rise events are scoreboarded.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_soc_ctrl_clk_rst_seq;

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            arst;
    logic [3:0]      ch_arst_a, clk_en_a, clk_en_o_a, ready_a;
    logic [3:0][7:0] delay_a;
    logic            busy_a;
    logic [3:0]      ch_arst_b, clk_en_b, clk_en_o_b, ready_b;
    logic [3:0][7:0] delay_b;
    logic            busy_b;

    int   cyc   = 0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    logic [3:0] prev_ready = 4'b0000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    soc_ctrl_clk_rst_seq #(.NUM_CH(4), .CNT_W(8), .SEQ_MODE(1)) u_dut_a (
        .clk_i       (clk),
        .arst_i      (arst),
        .ch_arst_ni  (ch_arst_a),
        .ch_clk_en_i (clk_en_a),
        .delay_i     (delay_a),
        .ch_clk_en_o (clk_en_o_a),
        .ch_ready_o  (ready_a),
        .busy_o      (busy_a)
    );

    soc_ctrl_clk_rst_seq #(.NUM_CH(4), .CNT_W(8), .SEQ_MODE(0)) u_dut_b (
        .clk_i       (clk),
        .arst_i      (arst),
        .ch_arst_ni  (ch_arst_b),
        .ch_clk_en_i (clk_en_b),
        .delay_i     (delay_b),
        .ch_clk_en_o (clk_en_o_b),
        .ch_ready_o  (ready_b),
        .busy_o      (busy_b)
    );

    task automatic chk_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input int ch, input int at);
        exp_t e;
        e.ch  = ch;
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every READY rise must match the oldest expected event.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ready_a[k] && !prev_ready[k]) begin
                if (exp_q.size() == 0) begin
                    chk_value("unexpected_ready_ch", k, 32'hFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk_value("ready_order_ch", k, e.ch);
                    chk_value("ready_cycle", cyc, e.cyc);
                end
            end
        end
        prev_ready <= ready_a;
    end

    task automatic at_neg(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk_value("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic hold_all_a();
        ch_arst_a = 4'b0000;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        arst      = 1'b1;
        ch_arst_a = 4'hF;
        clk_en_a  = 4'hF;
        delay_a   = '0;
        ch_arst_b = 4'hF;
        clk_en_b  = 4'hF;
        delay_b   = '0;
        repeat (3) @(negedge clk);
        chk_value("rst_ready_a",  ready_a,    4'h0);
        chk_value("rst_clken_a",  clk_en_o_a, 4'h0);
        chk_value("rst_busy_a",   busy_a,     1'b0);
        chk_value("rst_ready_b",  ready_b,    4'h0);

        ch_arst_a = 4'h0;
        ch_arst_b = 4'h0;
        arst      = 1'b0;
        repeat (4) @(negedge clk);

        // Independent mode: ch3 (delay 2) does not wait for ch2 (delay 0).
        delay_b[2] = 8'd0;
        delay_b[3] = 8'd2;
        t = cyc;
        ch_arst_b = 4'b1100;
        at_neg(t + 3);
        chk_value("indep_ready_t3", ready_b, 4'b0100);
        chk_value("indep_busy_t3",  busy_b,  1'b1);
        at_neg(t + 4);
        chk_value("indep_ready_t4", ready_b, 4'b0100);
        at_neg(t + 5);
        chk_value("indep_ready_t5", ready_b, 4'b1100);
        chk_value("indep_busy_t5",  busy_b,  1'b0);
        chk_value("indep_clken",    clk_en_o_b, 4'b1100);

        // Channel 0 alone, delay 50.
        delay_a[0] = 8'd50;
        t = cyc;
        ch_arst_a = 4'b0001;
        push_exp(0, t + 53);
        drain(80);
        clk_en_a[0] = 1'b0;
        #1 chk_value("clken_follow_lo", clk_en_o_a, 4'b0000);
        clk_en_a[0] = 1'b1;
        #1 chk_value("clken_follow_hi", clk_en_o_a, 4'b0001);

        // Simultaneous release in chained mode, delays {3,5,0,2}.
        hold_all_a();
        delay_a = {8'd2, 8'd0, 8'd5, 8'd3};
        t = cyc;
        ch_arst_a = 4'hF;
        push_exp(0, t + 6);
        push_exp(1, t + 12);
        push_exp(2, t + 13);
        push_exp(3, t + 16);
        at_neg(t + 15);
        chk_value("chain_busy_t15", busy_a, 1'b1);
        at_neg(t + 16);
        chk_value("chain_busy_t16", busy_a, 1'b0);
        drain(10);

        // Drop ch1 reset while all are READY; dependents fall back.
        t = cyc;
        ch_arst_a = 4'b1101;
        at_neg(t + 1);
        chk_value("drop_clken_t1", clk_en_o_a, 4'b1111);
        at_neg(t + 2);
        chk_value("drop_clken_t2", clk_en_o_a, 4'b1101);
        at_neg(t + 3);
        chk_value("drop_ready_t3", ready_a, 4'b1101);
        at_neg(t + 4);
        chk_value("drop_ready_t4", ready_a, 4'b1001);
        at_neg(t + 5);
        chk_value("drop_ready_t5", ready_a, 4'b0001);
        chk_value("drop_busy_t5",  busy_a,  1'b1);
        chk_value("drop_clken_t5", clk_en_o_a, 4'b0001);
        t = cyc;
        ch_arst_a = 4'hF;
        push_exp(1, t + 8);
        push_exp(2, t + 9);
        push_exp(3, t + 12);
        drain(20);

        // Delay input changes mid-COUNT must be ignored.
        hold_all_a();
        delay_a[0] = 8'd10;
        t = cyc;
        ch_arst_a = 4'b0001;
        push_exp(0, t + 13);
        at_neg(t + 5);
        delay_a[0] = 8'd200;
        drain(40);

        // Global reset while ch0 READY: outputs clear immediately.
        @(negedge clk);
        arst = 1'b1;
        #1;
        chk_value("arst_ready", ready_a,    4'h0);
        chk_value("arst_clken", clk_en_o_a, 4'h0);
        ch_arst_a = 4'h0;
        repeat (3) @(negedge clk);
        arst = 1'b0;
        repeat (2) @(negedge clk);

        // Global reset mid-COUNT aborts; full delay restarts afterwards.
        delay_a[0] = 8'd20;
        t = cyc;
        ch_arst_a = 4'b0001;
        at_neg(t + 6);
        chk_value("count_busy", busy_a, 1'b1);
        at_neg(t + 8);
        arst      = 1'b1;
        ch_arst_a = 4'h0;
        #1;
        chk_value("abort_busy",  busy_a,  1'b0);
        chk_value("abort_ready", ready_a, 4'h0);
        repeat (2) @(negedge clk);
        arst      = 1'b0;
        ch_arst_a = 4'b0001;
        t = cyc;
        push_exp(0, t + 23);
        drain(40);

        // Maximum delay, no wrap.
        hold_all_a();
        delay_a[0] = 8'd255;
        t = cyc;
        ch_arst_a = 4'b0001;
        push_exp(0, t + 258);
        drain(300);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_soc_ctrl_clk_rst_seq

`default_nettype wire

// File: doc/soc_ctrl_clk_rst_seq.md
SOC_CTRL_CLK_RST_SEQ -- requirements
Module: soc_ctrl_clk_rst_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent clock/reset channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of each channel's delay counter.
REQ-003 SHALL have parameter SEQ_MODE, default 1; 1 means channel k>0 may start only after channel k-1 is READY, 0 means channels are independent.
REQ-004 SHALL have port clk_i  input  1  reference clock; all state is in this domain.
REQ-005 SHALL have port arst_i  input  1  asynchronous, active-high global reset.
REQ-006 SHALL have port ch_arst_ni  input  NUM_CH  per-channel active-low reset, asynchronous to clk_i.
REQ-007 SHALL have port ch_clk_en_i  input  NUM_CH  per-channel requested clock enable.
REQ-008 SHALL have port delay_i  input  NUM_CH x CNT_W  per-channel release delay in clk_i cycles.
REQ-009 SHALL have port ch_clk_en_o  output  NUM_CH  per-channel qualified clock enable.
REQ-010 SHALL have port ch_ready_o  output  NUM_CH  channel is in READY.
REQ-011 SHALL have port busy_o  output  1  OR over all channels in WAIT_PRED or COUNT.

Function
REQ-012 SHALL synchronise each ch_arst_ni bit with a 2-flop synchroniser into clk_i (rst_sync[k]); rst_sync resets to 0.
REQ-013 SHALL implement one FSM per channel with states IDLE, WAIT_PRED, COUNT, READY.
REQ-014 IDLE: on the first cycle rst_sync[k]=1, the FSM SHALL go to WAIT_PRED if SEQ_MODE=1, k>0 and channel k-1 is not READY; otherwise to COUNT if delay_i[k]!=0; otherwise to READY.
REQ-015 WAIT_PRED: when channel k-1 is READY, the FSM SHALL go to COUNT, or to READY if delay_i[k]=0.
REQ-016 Entry into COUNT SHALL load the counter from delay_i[k], sampled on that cycle only; later changes to delay_i SHALL be ignored until the next entry.
REQ-017 COUNT SHALL last exactly delay_i[k] cycles and then go to READY; the counter SHALL decrement by 1 per cycle without wrap; the maximum is 2^CNT_W-1.
REQ-018 From any state, rst_sync[k]=0 SHALL force IDLE on the next cycle and clear the counter; this takes priority over every other transition.
REQ-019 With SEQ_MODE=1 and k>0, a channel in COUNT or READY SHALL return to WAIT_PRED on the next cycle once channel k-1 leaves READY; the counter restarts from delay_i on re-entry to COUNT.
REQ-020 Cascading SHALL apply: a chain of N dependents reaches WAIT_PRED within N cycles of the head channel leaving READY.
REQ-021 ch_clk_en_o[k] SHALL equal ch_clk_en_i[k] AND (state==READY) AND rst_sync[k], combinationally, so that gating is removed in the same cycle the synchronised reset drops.
REQ-022 ch_ready_o[k] SHALL be 1 only in READY.
REQ-023 Simultaneous release of all channels with SEQ_MODE=1 SHALL serialise: channel k enters COUNT on the cycle after channel k-1 enters READY.
REQ-024 Channel 0 SHALL never enter WAIT_PRED.

Reset
REQ-025 While arst_i=1, all FSMs SHALL be in IDLE, counters and synchronisers 0, and ch_clk_en_o, ch_ready_o and busy_o 0.
REQ-026 Deassertion of arst_i SHALL take effect on the next clk_i rising edge; arst_i asserted mid-COUNT SHALL abort immediately with no residual count.

Structure
REQ-027 A shared package soc_ctrl_pkg SHALL hold the state enum type soc_ctrl_seq_state_e and the SEQ_MODE encodings.
REQ-028 Per-channel logic SHALL live in one sub-module, soc_ctrl_clk_rst_seq_ch, instantiated NUM_CH times with a generate loop; the predecessor-READY input of channel 0 is tied to 1.

Verification
REQ-029 NUM_CH=4, SEQ_MODE=0, delay 50, release ch0 at t -> ch_ready_o[0] rises at t+2 (sync) +1 (IDLE exit) +50 cycles; ch_clk_en_o[0] follows ch_clk_en_i[0].
REQ-030 SEQ_MODE=1, delays {3,5,0,2}, release all together -> READY order ch0, ch1, ch2, ch3; ch2 READY one cycle after ch1; busy_o falls with ch3 READY.
REQ-031 All channels READY, drop ch_arst_ni[1] -> ch_clk_en_o[1]=0 two cycles later; ch2 and ch3 go to WAIT_PRED within 2 cycles; ch0 unaffected.
REQ-032 delay_i[0] changed from 10 to 200 mid-COUNT -> ch0 READY after exactly 10 cycles.
REQ-033 arst_i pulse during COUNT -> all outputs 0 same cycle; after release and re-release of the channel, the full delay restarts.
REQ-034 CNT_W=8, delay 255 -> READY after exactly 255 COUNT cycles; no wrap.
